// File: rtl/sqlite_row_capture_if.sv
// Capture-side and writer-side signals of the SQLite row capture stage.
// master: the environment (record source + DPI writer); slave: the capture stage.
interface sqlite_row_capture_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned DEPTH  = 16
);
  logic                     cap_valid;
  logic [DATA_W-1:0]        cap_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [TS_W-1:0]          out_ts;
  logic                     out_first;
  logic                     out_last;
  logic                     out_marker;
  logic [$clog2(DEPTH):0]   level;
  logic [15:0]              drop_cnt;
  logic                     overflow;

  modport master (
    output cap_valid, cap_data, flush, out_ready,
    input  out_valid, out_data, out_ts, out_first, out_last, out_marker,
    input  level, drop_cnt, overflow
  );

  modport slave (
    input  cap_valid, cap_data, flush, out_ready,
    output out_valid, out_data, out_ts, out_first, out_last, out_marker,
    output level, drop_cnt, overflow
  );
endinterface

// File: rtl/sqlite_row_capture.sv
// Timestamps captured records, buffers them in a FIFO and streams them to the
// SQLite writer with transaction boundary flags (first/last) and commit-only
// marker beats. Batches close on size, flush or idle timeout.
module sqlite_row_capture #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BATCH_SIZE = 8,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned TS_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  sqlite_row_capture_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BC_W   = $clog2(BATCH_SIZE) + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned ENT_W  = DATA_W + TS_W;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TS_W-1:0]   out_ts_q, out_ts_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic              out_marker_q, out_marker_d;
  logic [BC_W-1:0]   batch_cnt_q, batch_cnt_d;
  logic              first_pending_q, first_pending_d;
  logic              close_pending_q, close_pending_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic             out_free, fifo_empty, pop, wr, drop, row_last, marker_load, close_set;
  logic [ENT_W-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // Handshake and FIFO control decode.
  always_comb begin
    out_free    = !out_valid_q || bus.out_ready;
    fifo_empty  = (level_q == '0);
    pop         = out_free && !fifo_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr          = bus.cap_valid && ((level_q != LVL_W'(DEPTH)) || pop);
    drop        = bus.cap_valid && !wr;
    // A pending close ends the batch on the last buffered row, unless another row is arriving.
    row_last    = (batch_cnt_q == BC_W'(BATCH_SIZE - 1)) ||
                  (close_pending_q && (level_q == LVL_W'(1)) && !wr);
    marker_load = out_free && fifo_empty && close_pending_q && (batch_cnt_q != '0);
    close_set   = bus.flush || ((batch_cnt_q != '0) && (idle_cnt_q == IDLE_W'(TIMEOUT - 1)));
  end

  // Next-state for FIFO, output register, batch tracking and drop statistics.
  always_comb begin
    ts_d            = ts_q + TS_W'(1);
    wr_ptr_d        = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d         = level_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_ts_d        = out_ts_q;
    out_first_d     = out_first_q;
    out_last_d      = out_last_q;
    out_marker_d    = out_marker_q;
    batch_cnt_d     = batch_cnt_q;
    first_pending_d = first_pending_q;
    idle_cnt_d      = idle_cnt_q;
    drop_cnt_d      = drop_cnt_q;
    overflow_d      = overflow_q | drop;

    if (wr && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr && pop) begin
      level_d = level_q - LVL_W'(1);
    end

    if (pop) begin
      out_valid_d     = 1'b1;
      out_data_d      = head[DATA_W-1:0];
      out_ts_d        = head[ENT_W-1:DATA_W];
      out_first_d     = first_pending_q;
      out_last_d      = row_last;
      out_marker_d    = 1'b0;
      batch_cnt_d     = row_last ? '0 : batch_cnt_q + BC_W'(1);
      first_pending_d = row_last;
    end else if (marker_load) begin
      // Rows already went out without a last flag: commit with an empty beat.
      out_valid_d     = 1'b1;
      out_data_d      = '0;
      out_ts_d        = '0;
      out_first_d     = 1'b0;
      out_last_d      = 1'b1;
      out_marker_d    = 1'b1;
      batch_cnt_d     = '0;
      first_pending_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // A close request only matters while a batch stays open.
    close_pending_d = (close_pending_q || close_set) && (batch_cnt_d != '0);

    if (wr || (batch_cnt_d == '0)) begin
      idle_cnt_d = '0;
    end else if ((batch_cnt_q != '0) && (idle_cnt_q != IDLE_W'(TIMEOUT - 1))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= {ts_q, bus.cap_data};
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q            <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_ts_q        <= '0;
      out_first_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_marker_q    <= 1'b0;
      batch_cnt_q     <= '0;
      first_pending_q <= 1'b1;
      close_pending_q <= 1'b0;
      idle_cnt_q      <= '0;
      drop_cnt_q      <= '0;
      overflow_q      <= 1'b0;
    end else begin
      ts_q            <= ts_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_ts_q        <= out_ts_d;
      out_first_q     <= out_first_d;
      out_last_q      <= out_last_d;
      out_marker_q    <= out_marker_d;
      batch_cnt_q     <= batch_cnt_d;
      first_pending_q <= first_pending_d;
      close_pending_q <= close_pending_d;
      idle_cnt_q      <= idle_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ts     = out_ts_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_marker = out_marker_q;
  assign bus.level      = level_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: doc/sqlite_row_capture.md
# sqlite_row_capture

Capture-and-batch stage sitting directly upstream of the SQLite DPI writer. It timestamps monitored records from the DUT, buffers them in a FIFO, and presents them over a valid/ready stream. It also marks transaction boundaries: `out_first` tells the writer to call `sqlite_dpi_begin_transaction` before `sqlite_dpi_insert_row`, and `out_last` tells it to call `sqlite_dpi_commit_transaction` after the insert. Batches close on size, on an explicit flush, or on an idle timeout.

## Interface
- `DATA_W`, 32: record payload width.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BATCH_SIZE`, 8: maximum rows per transaction; ≥1.
- `TIMEOUT`, 64: idle cycles with an open batch before auto-close; ≥1.
- `TS_W`, 32: timestamp width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cap_valid` in 1: record present this cycle; no backpressure.
- `cap_data` in DATA_W: record payload.
- `flush` in 1: single-cycle request to close the open batch.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: writer accepts the beat.
- `out_data` out DATA_W: payload; 0 on marker beats.
- `out_ts` out TS_W: capture timestamp; 0 on marker beats.
- `out_first` out 1: first beat of a batch.
- `out_last` out 1: last beat of a batch.
- `out_marker` out 1: commit-only beat with no row; always has `out_last`=1.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, excluding the output register.
- `drop_cnt` out 16: saturating count of dropped records.
- `overflow` out 1: sticky; set on the first drop.

## Operation
- **Timestamp.** `ts` is a free-running TS_W counter, 0 at reset, and wraps modulo 2^TS_W. It is sampled into the FIFO together with `cap_data`.
- **Write path.**
  - `cap_valid` and (level<DEPTH or same-cycle FIFO pop) writes the entry.
  - Otherwise the record is dropped: `drop_cnt` increments, saturating at 0xFFFF, and `overflow` is set.
- **Output register.** Loads when it is empty or being handshaken (`out_valid`&&`out_ready`), and the FIFO is non-empty. A row load sets:
  - `out_first` = `first_pending`.
  - `out_last` = (`batch_cnt`==BATCH_SIZE-1) or (`close_pending` and the FIFO holds exactly this entry with no same-cycle write).
  - `batch_cnt`++, or `batch_cnt`=0 when `out_last`.
  - `first_pending` = `out_last`.
- **Marker load.** Occurs when the output register is free, the FIFO is empty, `close_pending`=1 and `batch_cnt`≠0. It loads `out_marker`=1, `out_last`=1, `out_first`=0, and sets `batch_cnt`=0, `first_pending`=1.
- **Close state.**
  - `close_pending` is set by `flush`, or when `idle_cnt` reaches TIMEOUT-1.
  - It is cleared when a beat with `out_last` is loaded, or when it is set while `batch_cnt`==0 (nothing open, so no effect).
  - Any load carrying `out_last` clears it.
- **Idle timer.** `idle_cnt` increments while `batch_cnt`≠0 and no FIFO write occurs. It resets to 0 on any write, and when `batch_cnt` becomes 0.
- **Reset values.** `out_valid`=0, `out_data`=0, `out_ts`=0, `out_first`=0, `out_last`=0, `out_marker`=0, `level`=0, `drop_cnt`=0, `overflow`=0. Internally: `first_pending`=1, `batch_cnt`=0, `close_pending`=0, `idle_cnt`=0, `ts`=0. Reset asserted mid-batch discards all contents; no marker is emitted.

## Timing
- **Latency.** Capture in cycle N: FIFO write at the end of N, output load at the end of N+1, `out_valid`=1 in cycle N+2 if the path is idle.
- **Throughput.** One beat per cycle while `out_ready`=1.
- **Handshake stability.** `out_*` hold stable while `out_valid`&&!`out_ready`; `out_valid` never drops without a handshake.
- **Simultaneous events.**
  - Write plus pop when full: accepted, level unchanged.
  - `flush` in the same cycle as a capture: the captured row joins the current batch.
  - `flush` while `out_last` is already loaded: no extra marker.
- **Level.** Changes by +1, -1 or 0 per cycle.
- **Wrap-around.** FIFO pointers wrap modulo DEPTH, and `ts` wraps silently.

## Test plan
- **Single batch:** 8 back-to-back captures 0..7 with `out_ready`=1 → 8 beats, `out_first` on data 0, `out_last` on data 7, `out_ts` strictly increasing by 1.
- **Flush mid-batch:** 3 captures, FIFO drained, then `flush` → marker beat (`out_marker`=1, `out_last`=1); the next capture carries `out_first`=1.
- **Timeout:** 2 captures, then idle with TIMEOUT=64 → `out_last` or marker appears 64 cycles after the last write, not before.
- **Overflow:** `out_ready`=0 and 20 captures with DEPTH=16 → `level`=16, `drop_cnt`=3 (16 in the FIFO plus 1 in the output register), `overflow`=1; draining returns data in order.
- **Backpressure:** random `out_ready` toggling over 100 records → `out_*` stable whenever stalled, no loss, batches of exactly 8 with `out_first`/`out_last` paired.
- **Reset mid-batch:** `rst_n` low during streaming → all outputs 0 immediately; the next capture carries `out_first`=1 and `ts` restarts from 0.
